// File: rtl/pip_regfile.sv
// Write-back register file: 2**ADDR_W x DATA_W, R0 reads as zero, two combinational read ports.
// Define RF_BYPASS_EN to forward the current write-back data to a matching read port.
module pip_regfile #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] w_addr,
    input  logic [DATA_W-1:0] w_data,
    input  logic [ADDR_W-1:0] r_addr1,
    input  logic [ADDR_W-1:0] r_addr2,
    output logic [DATA_W-1:0] r_data1,
    output logic [DATA_W-1:0] r_data2,
    output logic [15:0]       wr_count
);

    localparam int DEPTH = 2 ** ADDR_W;

    // R0 has no storage; entries 1..DEPTH-1 only.
    logic [DATA_W-1:0] regs [1:DEPTH-1];

    // NOTE: the array is reset because reads of a just-reset file must return zero
    // combinationally; this keeps it in flops rather than a RAM macro.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            wr_count <= '0;
        end else if (w_addr != '0) begin
            // NOTE: non-blocking so every register samples pre-edge values.
            regs[w_addr] <= w_data;
            wr_count     <= wr_count + 16'd1;
        end
    end

    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] ra);
        logic [DATA_W-1:0] rd;
        rd = '0;
        if (ra != '0) begin
            rd = regs[ra];
`ifdef RF_BYPASS_EN
            if (rst_n && (ra == w_addr)) begin
                rd = w_data;
            end
`endif
        end
        return rd;
    endfunction

    // NOTE: outputs get a default first so no path through the block infers a latch.
    always_comb begin
        r_data1 = '0;
        r_data2 = '0;
        r_data1 = read_port(r_addr1);
        r_data2 = read_port(r_addr2);
    end

endmodule

// File: tb/tb_pip_regfile.sv
// Self-checking bench for pip_regfile: directed cases plus random traffic against an array model.
module tb_pip_regfile;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 4;

    logic              clk;
    logic              rst_n;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;
    logic [ADDR_W-1:0] r_addr1;
    logic [ADDR_W-1:0] r_addr2;
    logic [DATA_W-1:0] r_data1;
    logic [DATA_W-1:0] r_data2;
    logic [15:0]       wr_count;

    pip_regfile #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .w_addr   (w_addr),
        .w_data   (w_data),
        .r_addr1  (r_addr1),
        .r_addr2  (r_addr2),
        .r_data1  (r_data1),
        .r_data2  (r_data2),
        .wr_count (wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain array of architectural values plus a write counter.
    logic [DATA_W-1:0] model_regs [16];
    logic [15:0]       model_cnt;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) model_regs[i] = '0;
        model_cnt = '0;
    endtask

    function automatic logic [DATA_W-1:0] exp_read(input logic [ADDR_W-1:0] ra);
        if (ra == 0) return '0;
`ifdef RF_BYPASS_EN
        if (rst_n && ra == w_addr) return w_data;
`endif
        return model_regs[ra];
    endfunction

    // One clock: drive inputs after the falling edge, check reads before the rising edge,
    // commit in the model at the rising edge, then check the counter.
    task automatic do_cycle(input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd,
                            input logic [ADDR_W-1:0] ra1, input logic [ADDR_W-1:0] ra2,
                            input bit do_check);
        @(negedge clk);
        w_addr = wa; w_data = wd; r_addr1 = ra1; r_addr2 = ra2;
        #1;
        if (do_check) begin
            check("r_data1", r_data1, exp_read(ra1));
            check("r_data2", r_data2, exp_read(ra2));
        end
        @(posedge clk);
        if (rst_n && wa != 0) begin
            model_regs[wa] = wd;
            model_cnt      = model_cnt + 16'd1;
        end
        #1;
        if (do_check) check("wr_count", wr_count, model_cnt);
    endtask

    // Assert reset between edges, verify immediate clearing, hold across an edge, release mid-cycle.
    task automatic mid_cycle_reset();
        @(negedge clk);
        r_addr1 = 4'd5; r_addr2 = 4'd3; w_addr = 4'd4; w_data = 16'h7777;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_r_data1", r_data1, 16'h0000);
        check("rst_wr_count", wr_count, 16'h0000);
        @(posedge clk); #1;
        r_addr1 = 4'd4;
        #1;
        check("rst_no_write", r_data1, 16'h0000);
        check("rst_no_count", wr_count, 16'h0000);
        @(negedge clk);
        w_addr = '0; w_data = '0;
        #2 rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; w_addr = '0; w_data = '0; r_addr1 = '0; r_addr2 = '0;
        model_reset();
        #1;
        check("init_r_data1", r_data1, 16'h0000);
        check("init_r_data2", r_data2, 16'h0000);
        check("init_wr_count", wr_count, 16'h0000);
        #20 rst_n = 1'b1;

        // Basic write/read and R0 protection
        do_cycle(4'd3, 16'hBEEF, 4'd0, 4'd0, 1'b1);
        do_cycle(4'd0, 16'h0000, 4'd3, 4'd3, 1'b1);
        check("basic_port1", r_data1, 16'hBEEF);
        check("basic_count", wr_count, 16'd1);
        do_cycle(4'd0, 16'hFFFF, 4'd0, 4'd3, 1'b1);
        do_cycle(4'd0, 16'h0000, 4'd0, 4'd0, 1'b1);
        check("r0_count", wr_count, 16'd1);

        // Same-cycle write/read of R7, then the following cycle
        do_cycle(4'd7, 16'hA5A5, 4'd0, 4'd7, 1'b1);
        do_cycle(4'd0, 16'h0000, 4'd7, 4'd7, 1'b1);
        check("bypass_next", r_data2, 16'hA5A5);

        // Back-to-back R1..R15 after a clean reset
        mid_cycle_reset();
        for (int i = 1; i < 16; i++)
            do_cycle(4'(i), 16'h0100 + 16'(i), 4'(i), 4'(16 - i), 1'b1);
        for (int i = 1; i < 16; i++)
            do_cycle(4'd0, 16'h0000, 4'(i), 4'(15 - i + 1), 1'b1);
        check("b2b_count", wr_count, 16'd15);
        do_cycle(4'd15, 16'h0000, 4'd15, 4'd1, 1'b1);
        do_cycle(4'd0, 16'h0000, 4'd15, 4'd15, 1'b1);
        check("overwrite_r15", r_data1, 16'h0000);
        check("overwrite_count", wr_count, 16'd16);

        // Reset mid-run after writing R5
        do_cycle(4'd5, 16'h1234, 4'd0, 4'd0, 1'b1);
        mid_cycle_reset();
        do_cycle(4'd6, 16'h4321, 4'd6, 4'd5, 1'b1);
        do_cycle(4'd0, 16'h0000, 4'd6, 4'd5, 1'b1);

        // Random traffic
        for (int n = 0; n < 600; n++)
            do_cycle(4'($urandom_range(0, 15)), 16'($urandom), 4'($urandom_range(0, 15)),
                     4'($urandom_range(0, 15)), 1'b1);
        for (int i = 0; i < 16; i++)
            do_cycle(4'd0, 16'h0000, 4'(i), 4'(15 - i), 1'b1);

        // Counter wrap: 65536 writes to R2 from reset
        mid_cycle_reset();
        for (int n = 0; n < 65535; n++)
            do_cycle(4'd2, 16'($urandom), 4'd0, 4'd0, 1'b0);
        check("wrap_ffff", wr_count, 16'hFFFF);
        do_cycle(4'd2, 16'($urandom), 4'd0, 4'd0, 1'b0);
        check("wrap_zero", wr_count, 16'h0000);
        do_cycle(4'd0, 16'h0000, 4'd2, 4'd2, 1'b1);
        check("wrap_r2", r_data1, model_regs[2]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
